// File: rtl/key_sync_pkg.sv
// Shared constants and types for the key synchroniser/debouncer.
package key_sync_pkg;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_BOTH = 2'd2
  } edge_mode_e;

  localparam int unsigned EVT_CNT_W = 8;

  // True when a transition to new_level should raise a pulse under mode.
  function automatic logic edge_match(input edge_mode_e mode, input logic new_level);
    return (mode == EDGE_BOTH) ||
           ((mode == EDGE_RISE) && new_level) ||
           ((mode == EDGE_FALL) && !new_level);
  endfunction

endpackage

// File: rtl/key_sync_chan.sv
// One key channel: synchroniser chain, debounce counter, edge pulse and,
// with KEY_SYNC_EVT_CNT_EN defined, a saturating pulse counter.
module key_sync_chan
  import key_sync_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter edge_mode_e  EDGE_MODE       = EDGE_FALL
) (
  input  logic clock,
  input  logic reset,
  input  logic key,
  output logic key_level,
  output logic key_pulse
`ifdef KEY_SYNC_EVT_CNT_EN
  ,
  output logic [EVT_CNT_W-1:0] evt_count
`endif
);

  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0]       cnt;
  logic                   sampled;

  assign sampled = sync[SYNC_STAGES-1];

  // The pulse is set in the same edge that updates key_level, so both
  // become visible together.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync      <= '0;
      cnt       <= '0;
      key_level <= 1'b0;
      key_pulse <= 1'b0;
    end else begin
      sync      <= {sync[SYNC_STAGES-2:0], key};
      key_pulse <= 1'b0;
      if (sampled == key_level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        key_level <= sampled;
        cnt       <= '0;
        key_pulse <= edge_match(EDGE_MODE, sampled);
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

`ifdef KEY_SYNC_EVT_CNT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      evt_count <= '0;
    end else if (key_pulse && (evt_count != '1)) begin
      evt_count <= evt_count + EVT_CNT_W'(1);
    end
  end
`endif

endmodule

// File: rtl/key_sync_edge.sv
// Multi-channel key synchroniser/debouncer with edge pulses.
// Define KEY_SYNC_EVT_CNT_EN to build the per-channel evt_count port.
module key_sync_edge
  import key_sync_pkg::*;
#(
  parameter int unsigned CHANNELS        = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter edge_mode_e  EDGE_MODE       = EDGE_FALL
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] key,
  output logic [CHANNELS-1:0] key_level,
  output logic [CHANNELS-1:0] key_pulse
`ifdef KEY_SYNC_EVT_CNT_EN
  ,
  output logic [EVT_CNT_W*CHANNELS-1:0] evt_count
`endif
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    key_sync_chan #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .EDGE_MODE      (EDGE_MODE)
    ) u_chan (
      .clock    (clock),
      .reset    (reset),
      .key      (key[i]),
      .key_level(key_level[i]),
      .key_pulse(key_pulse[i])
`ifdef KEY_SYNC_EVT_CNT_EN
      ,
      .evt_count(evt_count[EVT_CNT_W*i +: EVT_CNT_W])
`endif
    );
  end

endmodule

// File: doc/key_sync_edge.md
KEY_SYNC_EDGE -- requirements
Module: key_sync_edge

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent key inputs, range 1..16.
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser flop depth, range 2..4.
REQ-003 Parameter DEBOUNCE_CYCLES, default 4: consecutive mismatching samples required to accept a new level, range 1..65535.
REQ-004 Parameter EDGE_MODE, default EDGE_FALL: pulse trigger; EDGE_RISE=0, EDGE_FALL=1, EDGE_BOTH=2.
REQ-005 clock  input  1  single clock; all state changes on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 key  input  CHANNELS  asynchronous raw key levels, bit i = channel i.
REQ-008 key_level  output  CHANNELS  debounced, registered key level.
REQ-009 key_pulse  output  CHANNELS  one-cycle registered pulse on an accepted edge matching EDGE_MODE.
REQ-010 evt_count  output  8*CHANNELS  per-channel pulse counter, channel i at bits [8i+7:8i]; present only with KEY_SYNC_EVT_CNT_EN.

Function
REQ-011 Each channel SHALL pass key through SYNC_STAGES flops; the last stage is the sampled value S.
REQ-012 Each channel SHALL hold a counter of width clog2(DEBOUNCE_CYCLES)+1.
REQ-013 On each edge with S == key_level, the counter SHALL clear to 0.
REQ-014 On each edge with S != key_level and counter < DEBOUNCE_CYCLES-1, the counter SHALL increment.
REQ-015 On each edge with S != key_level and counter == DEBOUNCE_CYCLES-1, key_level SHALL take S and the counter SHALL clear.
REQ-016 A clean input step held stable SHALL appear on key_level exactly SYNC_STAGES+DEBOUNCE_CYCLES edges after the first sampling edge.
REQ-017 A glitch lasting fewer than DEBOUNCE_CYCLES sampled cycles SHALL leave key_level and key_pulse unchanged.
REQ-018 key_pulse[i] SHALL be high for exactly the first cycle in which key_level[i] shows a new value, and only if the edge direction matches EDGE_MODE.
REQ-019 With DEBOUNCE_CYCLES=1, key_level SHALL equal S delayed by one edge, with no filtering.
REQ-020 Channels SHALL be fully independent; simultaneous edges on several channels SHALL each produce their own pulse in the same cycle.
REQ-021 With KEY_SYNC_EVT_CNT_EN, evt_count[i] SHALL increment on each cycle with key_pulse[i]=1 and saturate at 255.

Reset
REQ-022 While reset=1 at an edge, all synchroniser flops, counters, key_level, key_pulse and evt_count SHALL become 0.
REQ-023 Reset asserted mid-debounce SHALL abort the pending change; no pulse SHALL be emitted for it.
REQ-024 After reset release with key held high, the channel SHALL accept the high level through the normal path (REQ-016) and pulse if EDGE_MODE is EDGE_RISE or EDGE_BOTH.

Configuration
REQ-025 Macro KEY_SYNC_EVT_CNT_EN defined: evt_count port and saturating counters are built.
REQ-026 Macro KEY_SYNC_EVT_CNT_EN undefined: the evt_count port and its logic are absent; all other behaviour is identical.

Structure
REQ-027 Package key_sync_pkg SHALL hold the EDGE_RISE/EDGE_FALL/EDGE_BOTH constants, the edge-mode typedef and the 8-bit counter width constant.
REQ-028 Sub-module key_sync_chan (one channel: synchroniser, debounce counter, edge logic, optional counter) SHALL be instantiated CHANNELS times by a generate loop.

Verification
REQ-029 Defaults, key[0] 0->1 held: key_level[0]=1 exactly 6 edges later; no key_pulse (EDGE_FALL).
REQ-030 Defaults, key[0] 1->0 after settling: key_pulse[0]=1 for one cycle, coincident with key_level[0] falling, 6 edges after the change.
REQ-031 Defaults, 3-cycle low glitch on a settled high key[1]: key_level[1] stays 1 and no pulse occurs.
REQ-032 EDGE_BOTH, key[3:0] toggled together: four pulses in the same cycle on the rise and four on the fall.
REQ-033 Reset asserted 2 edges into a debounce: all outputs read 0 and no pulse follows reset release with key low.
REQ-034 With KEY_SYNC_EVT_CNT_EN, 300 accepted falling edges on channel 2: evt_count[23:16]=255 and the other channels read 0.
